// File: rtl/alu_muldiv_seq_if.sv
// alu_muldiv_seq_if
// Groups the operation request and result signals of the iterative
// multiply/divide unit so that they travel between the execute stage and
// the unit as one bundle.
//   master : drives start/op/setcc/kill/a/b/y_in, reads the results
//   slave  : the muldiv unit itself
// Request : start, op[1:0], setcc, kill, a, b, y_in
// Result  : ready, busy, done, res, y_out, y_we, trap, N, Z, V, C, cc_we
interface alu_muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic             setcc;
  logic             kill;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] y_in;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] y_out;
  logic             y_we;
  logic             trap;
  logic             N;
  logic             Z;
  logic             V;
  logic             C;
  logic             cc_we;

  modport master (
    output start, op, setcc, kill, a, b, y_in,
    input  ready, busy, done, res, y_out, y_we, trap, N, Z, V, C, cc_we
  );

  modport slave (
    input  start, op, setcc, kill, a, b, y_in,
    output ready, busy, done, res, y_out, y_we, trap, N, Z, V, C, cc_we
  );
endinterface

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq
// Iterative SPARC V8 multiply/divide unit (UMUL, SMUL, UDIV, SDIV and the
// cc variants). Multiplies are radix-2 shift-add, divides are restoring;
// both take one bit per cycle over a shared 2W accumulator. Signed ops are
// done on magnitudes and the sign is re-applied in the FIX state. Divide by
// zero traps and unsigned quotient overflow saturates without iterating.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : alu_muldiv_seq_if.slave (request, results, cc, handshake)
// Build option:
//   ALU_MULDIV_CC_EN : when defined, the N/Z/V/C flags and cc_we are built;
//                      otherwise they are constant 0 and setcc is ignored.
module alu_muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input logic               clk,
  input logic               rst_n,
  alu_muldiv_seq_if.slave   bus
);

  localparam logic [WIDTH-1:0] MAXPOS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MINNEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t             state, next_state;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         op_q;
  logic               trap_q;
  logic               neg_q;
  logic [WIDTH-1:0]   p_hi;
  logic [WIDTH-1:0]   p_lo;
  logic [WIDTH-1:0]   dvs;
  logic [WIDTH-1:0]   res_q;
  logic [WIDTH-1:0]   yout_q;

`ifdef ALU_MULDIV_CC_EN
  logic               setcc_q;
  logic               n_q, z_q, v_q;
  logic               fin_cc;
`else
  logic               setcc_unused;
  assign setcc_unused = bus.setcc;
`endif

  // Capture-time operand conditioning: magnitudes, result sign, fast paths.
  logic                 launch;
  logic [WIDTH-1:0]     a_mag, b_mag, sat;
  logic [2*WIDTH-1:0]   dvd_raw, dvd_mag;
  logic                 sign_in, div_zero, div_ovf;

  assign launch   = (state == IDLE) && bus.start && !bus.kill;
  assign dvd_raw  = {bus.y_in, bus.a};
  assign dvd_mag  = (bus.op == 2'b11 && bus.y_in[WIDTH-1]) ? -dvd_raw : dvd_raw;
  assign a_mag    = (bus.op == 2'b01 && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign b_mag    = (bus.op[0] && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  assign sign_in  = bus.op[0] &
                    ((bus.op[1] ? bus.y_in[WIDTH-1] : bus.a[WIDTH-1]) ^ bus.b[WIDTH-1]);
  assign div_zero = bus.op[1] && (bus.b == '0);
  // A high half at or above the divisor means the quotient cannot fit in W bits.
  assign div_ovf  = bus.op[1] && !div_zero && (dvd_mag[2*WIDTH-1:WIDTH] >= b_mag);
  assign sat      = bus.op[0] ? (sign_in ? MINNEG : MAXPOS) : '1;

  // Per-iteration datapath for both algorithms.
  logic [WIDTH:0]       mul_sum, div_shift;
  logic [WIDTH-1:0]     div_diff;
  logic                 div_ge;
  logic [2*WIDTH-1:0]   prod_fix;

  assign mul_sum   = {1'b0, p_hi} + (p_lo[0] ? {1'b0, dvs} : '0);
  assign div_shift = {p_hi, p_lo[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, dvs};
  // The kept remainder is always below the divisor, so W bits suffice.
  assign div_diff  = div_shift[WIDTH-1:0] - dvs;
  assign prod_fix  = neg_q ? -{p_hi, p_lo} : {p_hi, p_lo};

  // Result finalisation, either from the fast path or from FIX.
  logic                 fin_wr, fin_v;
  logic [WIDTH-1:0]     fin_res, fin_y;

  always_comb begin
    fin_wr  = 1'b0;
    fin_v   = 1'b0;
    fin_res = res_q;
    fin_y   = yout_q;
`ifdef ALU_MULDIV_CC_EN
    fin_cc  = 1'b0;
`endif
    if (launch && (div_zero || div_ovf)) begin
      // Divide by zero leaves every held output alone.
      fin_wr  = div_ovf;
      fin_res = sat;
      fin_v   = 1'b1;
`ifdef ALU_MULDIV_CC_EN
      fin_cc  = bus.setcc && div_ovf;
`endif
    end else if (state == FIX && !bus.kill) begin
      fin_wr = 1'b1;
`ifdef ALU_MULDIV_CC_EN
      fin_cc = setcc_q;
`endif
      if (!op_q[1]) begin
        fin_res = prod_fix[WIDTH-1:0];
        fin_y   = prod_fix[2*WIDTH-1:WIDTH];
      end else if (op_q[0] && !neg_q && p_lo[WIDTH-1]) begin
        fin_res = MAXPOS;
        fin_v   = 1'b1;
      end else if (op_q[0] && neg_q && p_lo[WIDTH-1] && (p_lo[WIDTH-2:0] != '0)) begin
        fin_res = MINNEG;
        fin_v   = 1'b1;
      end else begin
        fin_res = neg_q ? -p_lo : p_lo;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic; kill always returns to IDLE.
  always_comb begin
    next_state = state;
    if (bus.kill) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: if (bus.start) next_state = (div_zero || div_ovf) ? DONE : CALC;
        CALC: if (cnt == CNT_W'(1)) next_state = FIX;
        FIX:  next_state = DONE;
        DONE: next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // Datapath and held result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      op_q   <= '0;
      trap_q <= 1'b0;
      neg_q  <= 1'b0;
      p_hi   <= '0;
      p_lo   <= '0;
      dvs    <= '0;
      res_q  <= '0;
      yout_q <= '0;
`ifdef ALU_MULDIV_CC_EN
      setcc_q <= 1'b0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
      v_q     <= 1'b0;
`endif
    end else begin
      if (launch) begin
        cnt    <= CNT_W'(WIDTH);
        op_q   <= bus.op;
        trap_q <= div_zero;
        neg_q  <= sign_in;
        p_hi   <= bus.op[1] ? dvd_mag[2*WIDTH-1:WIDTH] : '0;
        p_lo   <= bus.op[1] ? dvd_mag[WIDTH-1:0] : a_mag;
        dvs    <= b_mag;
`ifdef ALU_MULDIV_CC_EN
        setcc_q <= bus.setcc;
`endif
      end else if (state == CALC) begin
        cnt <= cnt - CNT_W'(1);
        if (!op_q[1]) begin
          p_hi <= mul_sum[WIDTH:1];
          p_lo <= {mul_sum[0], p_lo[WIDTH-1:1]};
        end else begin
          p_hi <= div_ge ? div_diff : div_shift[WIDTH-1:0];
          p_lo <= {p_lo[WIDTH-2:0], div_ge};
        end
      end
      if (fin_wr) begin
        res_q  <= fin_res;
        yout_q <= fin_y;
      end
`ifdef ALU_MULDIV_CC_EN
      if (fin_cc) begin
        n_q <= fin_res[WIDTH-1];
        z_q <= (fin_res == '0);
        v_q <= fin_v;
      end
`endif
    end
  end

  // Output decode from registered state.
  always_comb begin
    bus.ready = (state == IDLE);
    bus.busy  = (state != IDLE);
    bus.done  = (state == DONE);
    bus.res   = res_q;
    bus.y_out = yout_q;
    bus.y_we  = (state == DONE) && !op_q[1];
    bus.trap  = (state == DONE) && trap_q;
    bus.C     = 1'b0;
`ifdef ALU_MULDIV_CC_EN
    bus.cc_we = (state == DONE) && setcc_q && !trap_q;
    bus.N     = n_q;
    bus.Z     = z_q;
    bus.V     = v_q;
`else
    bus.cc_we = 1'b0;
    bus.N     = 1'b0;
    bus.Z     = 1'b0;
    bus.V     = 1'b0;
`endif
  end

endmodule
